// File: rtl/ines_pkg.sv
// Shared constants and types for the iNES cartridge loader.
// Holds the header magic, FSM state encodings, section lengths and the SDRAM write entry.
package ines_pkg;

  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_TRAINER = 3'd2;
  localparam logic [2:0] ST_PRG     = 3'd3;
  localparam logic [2:0] ST_CHR     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  localparam int TRAINER_LEN = 512;
  localparam int PRG_BANK    = 16384;
  localparam int CHR_BANK    = 8192;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

endpackage

// File: rtl/ines_byte_fifo.sv
// Small FIFO of pending SDRAM writes ({addr, data}) between the stream parser and the drain port.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module ines_byte_fifo
  import ines_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      flush,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  wr_entry_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + PTR_ONE;
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ines_loader.sv
// Parses an iNES image streamed from iosys, writes PRG/CHR bytes to SDRAM through a req/ack
// port, and presents the decoded cartridge parameters.
module ines_loader
  import ines_pkg::*;
#(
  parameter logic [21:0] CHR_BASE       = 22'h20_0000,
  parameter int          PRG_MAX_BANKS  = 128,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          PRG_BANK_BYTES = PRG_BANK,
  parameter int          CHR_BANK_BYTES = CHR_BANK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        header_valid,
  output logic [7:0]  mapper,
  output logic [7:0]  prg_banks,
  output logic [7:0]  chr_banks,
  output logic        mirroring,
  output logic        battery,
  output logic        loaded,
  output logic        error
);

  logic [2:0]  state;
  logic        loading_q, valid_q;
  logic [21:0] cnt;
  logic [31:0] magic;
  logic [7:0]  prg_raw, chr_raw;
  logic [3:0]  map_lo, map_hi;
  logic        trn_raw, bat_raw, mir_raw;

  logic        load_rise, load_fall, accept, push, overflow, pop, fifo_full, fifo_empty;
  logic        active, hdr_ok;
  wr_entry_t   push_entry, head;
  logic [21:0] prg_last, chr_last;

  assign load_rise = rom_loading & ~loading_q;
  assign load_fall = ~rom_loading & loading_q;
  assign accept    = rom_do_valid & ~valid_q & ~load_rise;
  assign active    = (state == ST_HEADER) || (state == ST_TRAINER) ||
                     (state == ST_PRG)    || (state == ST_CHR);

  assign prg_last = 22'(int'(prg_banks) * PRG_BANK_BYTES - 1);
  assign chr_last = 22'(int'(chr_banks) * CHR_BANK_BYTES - 1);
  assign hdr_ok   = (magic == INES_MAGIC) && (prg_raw != 8'd0) &&
                    (int'(prg_raw) <= PRG_MAX_BANKS);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_entry = '{addr: cnt, data: rom_do};
    if (accept && !load_fall) begin
      if (state == ST_PRG) begin
        push = 1'b1;
      end else if (state == ST_CHR) begin
        push            = 1'b1;
        push_entry.addr = CHR_BASE + cnt;
      end
    end
  end

  assign overflow = push && fifo_full;
  assign pop      = !mem_req && !fifo_empty && !load_rise;

  ines_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (load_rise),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      loading_q    <= 1'b0;
      valid_q      <= 1'b0;
      cnt          <= '0;
      magic        <= '0;
      prg_raw      <= '0;
      chr_raw      <= '0;
      map_lo       <= '0;
      map_hi       <= '0;
      trn_raw      <= 1'b0;
      bat_raw      <= 1'b0;
      mir_raw      <= 1'b0;
      header_valid <= 1'b0;
      mapper       <= '0;
      prg_banks    <= '0;
      chr_banks    <= '0;
      mirroring    <= 1'b0;
      battery      <= 1'b0;
    end else begin
      loading_q <= rom_loading;
      valid_q   <= rom_do_valid;
      if (load_rise) begin
        state        <= ST_HEADER;
        cnt          <= '0;
        magic        <= '0;
        prg_raw      <= '0;
        chr_raw      <= '0;
        map_lo       <= '0;
        map_hi       <= '0;
        trn_raw      <= 1'b0;
        bat_raw      <= 1'b0;
        mir_raw      <= 1'b0;
        header_valid <= 1'b0;
        mapper       <= '0;
        prg_banks    <= '0;
        chr_banks    <= '0;
        mirroring    <= 1'b0;
        battery      <= 1'b0;
      end else if ((load_fall && active) || overflow) begin
        state <= ST_ERROR;
      end else if (accept) begin
        case (state)
          ST_HEADER: begin
            cnt <= cnt + 22'd1;
            case (cnt[3:0])
              4'd0, 4'd1, 4'd2, 4'd3: magic <= {rom_do, magic[31:8]};
              4'd4: prg_raw <= rom_do;
              4'd5: chr_raw <= rom_do;
              4'd6: begin
                map_lo  <= rom_do[7:4];
                trn_raw <= rom_do[2];
                bat_raw <= rom_do[1];
                mir_raw <= rom_do[0];
              end
              4'd7: map_hi <= rom_do[7:4];
              default: ;
            endcase
            if (cnt == 22'd15) begin
              cnt       <= '0;
              prg_banks <= prg_raw;
              chr_banks <= chr_raw;
              mapper    <= {map_hi, map_lo};
              mirroring <= mir_raw;
              battery   <= bat_raw;
              if (hdr_ok) begin
                header_valid <= 1'b1;
                state        <= trn_raw ? ST_TRAINER : ST_PRG;
              end else begin
                state <= ST_ERROR;
              end
            end
          end
          ST_TRAINER: begin
            cnt <= cnt + 22'd1;
            if (cnt == 22'(TRAINER_LEN - 1)) begin
              cnt   <= '0;
              state <= ST_PRG;
            end
          end
          ST_PRG: begin
            cnt <= cnt + 22'd1;
            if (cnt == prg_last) begin
              cnt   <= '0;
              state <= (chr_banks == 8'd0) ? ST_DONE : ST_CHR;
            end
          end
          ST_CHR: begin
            cnt <= cnt + 22'd1;
            if (cnt == chr_last) begin
              cnt   <= '0;
              state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A load restart drops the in-flight request along with the FIFO contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_rise) begin
      mem_req <= 1'b0;
    end else if (pop) begin
      mem_req   <= 1'b1;
      mem_addr  <= head.addr;
      mem_wdata <= head.data;
    end else if (mem_req && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  assign error  = (state == ST_ERROR);
  assign loaded = (state == ST_DONE) && fifo_empty && !mem_req && !rom_loading;

endmodule

// File: tb/tb_ines_loader.sv
// Scoreboard bench for ines_loader with scaled-down bank sizes so whole images fit in a short run.
// Stimulus queues expected SDRAM writes; a monitor acts as SDRAM, pops and compares each request.
module tb_ines_loader;
  import ines_pkg::*;

  localparam int          PRG_SZ = 64;
  localparam int          CHR_SZ = 32;
  localparam logic [21:0] CBASE  = 22'h20_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rom_loading = 1'b0;
  logic [7:0]  rom_do = 8'h00;
  logic        rom_do_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        header_valid, mirroring, battery, loaded, error;
  logic [7:0]  mapper, prg_banks, chr_banks;

  ines_loader #(
    .CHR_BASE(CBASE), .PRG_MAX_BANKS(128), .FIFO_DEPTH(4),
    .PRG_BANK_BYTES(PRG_SZ), .CHR_BANK_BYTES(CHR_SZ)
  ) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .header_valid(header_valid),
    .mapper(mapper), .prg_banks(prg_banks), .chr_banks(chr_banks),
    .mirroring(mirroring), .battery(battery), .loaded(loaded), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [29:0] exp_q[$];
  int          writes = 0;
  int          stall_next = 0;
  int          first_req_cyc = -1;
  logic [21:0] first_addr = '0;
  logic [7:0]  first_data = '0;
  int          byte_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + (i >> 8) + 3);
  endfunction

  // SDRAM model and checker
  initial begin : monitor
    logic [29:0] exp_e;
    int          lat;
    bit          aborted;
    forever begin
      @(posedge clk); #1;
      if (mem_req && resetn) begin
        if (writes == 0) begin
          first_req_cyc = cyc;
          first_addr    = mem_addr;
          first_data    = mem_wdata;
        end
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
          exp_e = {mem_addr, mem_wdata};
        end else begin
          exp_e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(exp_e[29:8]));
          check("write_data", 32'(mem_wdata), 32'(exp_e[7:0]));
        end
        lat        = (stall_next > 0) ? stall_next : 1;
        stall_next = 0;
        aborted    = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (!mem_req) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          check("hold_addr", 32'(mem_addr), 32'(exp_e[29:8]));
          check("hold_data", 32'(mem_wdata), 32'(exp_e[7:0]));
          mem_ack = 1'b1;
          @(posedge clk); #1;
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Each byte occupies exactly 4 cycles; the strobe is held for 1 or 2 of them.
  task automatic send_byte(input logic [7:0] b);
    int hold;
    hold = (byte_no % 2) + 1;
    byte_no++;
    rom_do       = b;
    rom_do_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rom_do_valid = 1'b0;
    repeat (4 - hold) @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    writes        = 0;
    first_req_cyc = -1;
    rom_loading   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_load();
    rom_loading = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_header(input logic [7:0] m2, input logic [7:0] prg, input logic [7:0] chr,
                             input logic [7:0] f6, input logic [7:0] f7);
    logic [7:0] hdr [16];
    hdr = '{8'h4E, 8'h45, 8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    hdr[2] = m2;
    hdr[4] = prg;
    hdr[5] = chr;
    hdr[6] = f6;
    hdr[7] = f7;
    for (int i = 0; i < 16; i++) send_byte(hdr[i]);
  endtask

  // kind: 0 = not written, 1 = PRG/CHR write expected at addr0 + i
  task automatic send_data(input int first_idx, input int n, input int kind, input int addr0);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = pat(first_idx + i);
      if (kind != 0) exp_q.push_back({22'(addr0 + i), b});
      send_byte(b);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mem_req) && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_req", 32'(mem_req), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_header_valid", 32'(header_valid), 0);
    check("reset_fields", {mapper, prg_banks, chr_banks, 6'd0, mirroring, battery}, 0);
    check("reset_loaded_error", {loaded, error}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Minimal image: 1 PRG, 1 CHR, vertical mirroring
    start_load();
    send_header(8'h53, 8'd1, 8'd1, 8'h01, 8'h00);
    check("min_header_valid", 32'(header_valid), 1);
    check("min_mapper", 32'(mapper), 0);
    check("min_mirroring", 32'(mirroring), 1);
    check("min_banks", {prg_banks, chr_banks}, 32'h0101);
    acc = cyc;
    send_data(16, PRG_SZ, 1, 0);
    check("min_req_latency", 32'(first_req_cyc - acc), 2);
    send_data(16 + PRG_SZ, CHR_SZ, 1, int'(CBASE));
    wait_drain("min");
    check("min_loaded_while_loading", 32'(loaded), 0);
    check("min_writes", 32'(writes), 32'(PRG_SZ + CHR_SZ));
    end_load();
    check("min_loaded", 32'(loaded), 1);
    check("min_error", 32'(error), 0);

    // Trainer plus mapper 0x41, 2 PRG banks, no CHR, extra trailing bytes
    start_load();
    send_header(8'h53, 8'd2, 8'd0, 8'h14, 8'h40);
    check("trn_mapper", 32'(mapper), 32'h41);
    check("trn_header_valid", 32'(header_valid), 1);
    check("trn_mirror_battery", {mirroring, battery}, 0);
    send_data(16, TRAINER_LEN, 0, 0);
    check("trn_no_trainer_writes", 32'(writes), 0);
    send_data(528, 2 * PRG_SZ, 1, 0);
    send_data(528 + 2 * PRG_SZ, 3, 0, 0);
    wait_drain("trn");
    check("trn_first_addr", 32'(first_addr), 0);
    check("trn_first_data", 32'(first_data), 32'(pat(528)));
    check("trn_writes", 32'(writes), 32'(2 * PRG_SZ));
    end_load();
    check("trn_loaded", 32'(loaded), 1);

    // Bad magic
    start_load();
    send_header(8'h00, 8'd1, 8'd1, 8'h00, 8'h00);
    check("bad_magic_error", 32'(error), 1);
    check("bad_magic_header_valid", 32'(header_valid), 0);
    send_data(16, 8, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("bad_magic_writes", 32'(writes), 0);
    end_load();
    check("bad_magic_loaded", 32'(loaded), 0);

    // PRG bank count bounds: 0 and 129 rejected, 128 accepted
    start_load();
    check("restart_clears_error", 32'(error), 0);
    send_header(8'h53, 8'd0, 8'd1, 8'h00, 8'h00);
    check("prg0_error", 32'(error), 1);
    end_load();
    start_load();
    send_header(8'h53, 8'd129, 8'd0, 8'h00, 8'h00);
    check("prg129_error", 32'(error), 1);
    check("prg129_header_valid", 32'(header_valid), 0);
    end_load();
    start_load();
    send_header(8'h53, 8'd128, 8'd0, 8'h00, 8'h00);
    check("prg128_header_valid", 32'(header_valid), 1);
    check("prg128_error", 32'(error), 0);
    end_load();
    check("prg128_truncated_error", 32'(error), 1);

    // 20-cycle SDRAM stall overflows the FIFO on the sixth byte
    start_load();
    send_header(8'h53, 8'd1, 8'd0, 8'h00, 8'h00);
    stall_next = 20;
    send_data(16, 5, 1, 0);
    send_data(21, 3, 0, 0);
    check("stall20_error", 32'(error), 1);
    wait_drain("stall20");
    check("stall20_writes", 32'(writes), 5);
    end_load();
    check("stall20_loaded", 32'(loaded), 0);

    // 12-cycle stall is absorbed
    start_load();
    send_header(8'h53, 8'd1, 8'd0, 8'h00, 8'h00);
    stall_next = 12;
    send_data(16, PRG_SZ, 1, 0);
    wait_drain("stall12");
    check("stall12_error", 32'(error), 0);
    check("stall12_writes", 32'(writes), 32'(PRG_SZ));
    end_load();
    check("stall12_loaded", 32'(loaded), 1);

    // Truncation mid-PRG: queued writes still complete
    start_load();
    send_header(8'h53, 8'd2, 8'd0, 8'h00, 8'h00);
    send_data(16, 100, 1, 0);
    end_load();
    check("trunc_error", 32'(error), 1);
    wait_drain("trunc");
    check("trunc_writes", 32'(writes), 100);
    check("trunc_loaded", 32'(loaded), 0);

    // Asynchronous reset mid-PRG
    start_load();
    send_header(8'h53, 8'd1, 8'd0, 8'h00, 8'h00);
    send_data(16, 10, 1, 0);
    check("pre_reset_header_valid", 32'(header_valid), 1);
    #3 resetn = 1'b0;
    #1;
    check("async_reset_mem_req", 32'(mem_req), 0);
    check("async_reset_header", {header_valid, prg_banks, mapper}, 0);
    check("async_reset_status", {loaded, error, mem_addr}, 0);
    exp_q.delete();
    rom_loading = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Restart mid-CHR
    start_load();
    send_header(8'h53, 8'd1, 8'd1, 8'h01, 8'h00);
    send_data(16, PRG_SZ, 1, 0);
    send_data(16 + PRG_SZ, 10, 1, int'(CBASE));
    wait_drain("midchr");
    end_load();
    check("midchr_fall_error", 32'(error), 1);
    start_load();
    check("restart_error", 32'(error), 0);
    check("restart_fields", {header_valid, mirroring, prg_banks, chr_banks}, 0);
    send_header(8'h53, 8'd1, 8'd0, 8'h00, 8'h00);
    send_data(16, PRG_SZ, 1, 0);
    wait_drain("restart");
    check("restart_first_addr", 32'(first_addr), 0);
    check("restart_writes", 32'(writes), 32'(PRG_SZ));
    end_load();
    check("restart_loaded", 32'(loaded), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ines_loader.md
# ines_loader

Consumes the byte stream that the IO subsystem emits on its ROM loading interface (`rom_loading`, `rom_do`, `rom_do_valid`). It parses the 16-byte iNES header, skips any trainer, and writes PRG and CHR data into SDRAM through a req/ack port. It then presents the decoded cartridge parameters to the NES core and mapper logic. It sits between iosys and the SDRAM arbiter, on the game-data side.

## Interface
Parameters:
- `CHR_BASE`, default 22'h20_0000: SDRAM byte address of CHR byte 0. PRG byte 0 is written at address 0.
- `PRG_MAX_BANKS`, default 128: largest legal PRG size, in 16 KB banks.
- `FIFO_DEPTH`, default 4: byte buffer depth (power of 2).

Ports:
- `clk` in 1: system clock. One clock domain; everything is synchronous to `clk`.
- `resetn` in 1: reset, asynchronous and active-low.
- `rom_loading` in 1: rising edge starts a load; falling edge ends it.
- `rom_do` in 8: stream byte.
- `rom_do_valid` in 1: byte strobe.
- `mem_req` out 1: SDRAM write request, held until acknowledged.
- `mem_ack` in 1: one-cycle completion pulse from SDRAM.
- `mem_addr` out 22: write byte address.
- `mem_wdata` out 8: write data.
- `header_valid` out 1: level; the header parsed and passed all checks.
- `mapper` out 8: `{byte7[7:4], byte6[7:4]}`.
- `prg_banks` out 8: header byte 4.
- `chr_banks` out 8: header byte 5.
- `mirroring` out 1: byte6[0].
- `battery` out 1: byte6[1].
- `loaded` out 1: level; the image is completely in SDRAM.
- `error` out 1: sticky error level.

## Operation
- **Byte acceptance.** A byte is taken when `rom_do_valid` is high and was low on the previous cycle (rising edge). The strobe may be held high 1–2 cycles per byte. Bytes are at least 4 cycles apart.
- **Load start.** On a `rom_loading` rising edge:
  - clear all counters, header fields, `header_valid`, `loaded` and `error`;
  - flush the FIFO and drop any pending request;
  - go to HEADER.
- **State IDLE.** Stream bytes are ignored.
- **State HEADER.** Store bytes 0–15. After byte 15:
  - If bytes 0–3 ≠ 4E 45 53 1A, or `prg_banks` is 0, or `prg_banks` > `PRG_MAX_BANKS`, go to ERROR.
  - Otherwise set `header_valid`. If byte6[2] is set, go to TRAINER; if not, go to PRG.
- **State TRAINER.** Discard 512 bytes, then go to PRG.
- **State PRG.** Push each byte into the FIFO together with address = PRG byte count. After `prg_banks`×16384 bytes, go to CHR, or to DONE if `chr_banks` is 0.
- **State CHR.** Push each byte with address = `CHR_BASE` + CHR byte count. After `chr_banks`×8192 bytes, go to DONE.
- **State DONE.** Extra bytes are ignored.
- **State ERROR.** `error` is 1 and stream bytes are ignored. The state is left only by a new `rom_loading` rise or by reset.
- **Drain side.** When the FIFO is not empty and no request is outstanding, pop one entry and assert `mem_req` with its address and data. Address and data stay stable until the cycle `mem_ack` is seen; `mem_req` drops in the following cycle.
- **`loaded`.** Set when the state is DONE, the FIFO is empty, no request is outstanding, and `rom_loading` is 0.
- **`rom_loading` falls early.** If it falls in HEADER, TRAINER, PRG or CHR, go to ERROR (truncated image). Writes already queued still drain.
- **Overflow.** A push into a full FIFO sets `error`, drops the byte, and moves to ERROR.
- **Simultaneous accept and `rom_loading` rise.** The rise wins and the byte is discarded.

## Timing
- **Reset values.** All outputs are 0; state is IDLE; FIFO is empty.
- **Byte to request latency.** A byte accepted at cycle N is written into the FIFO at N+1. `mem_req` rises at N+2 if the FIFO was empty and the port idle.
- **Header decode.** `header_valid` and the decoded fields update 1 cycle after byte 15 is accepted.
- **Throughput.** At most one SDRAM write per `mem_ack`. Because bytes arrive at most every 4 cycles, the 4-deep FIFO absorbs SDRAM latency of up to 16 cycles without loss.
- **Counter widths.** Byte counters are 22 bits and must not wrap: the maximum image is 128×16 KB PRG + 255×8 KB CHR.

## Structure
- **Shared package `ines_pkg`:**
  - magic constant 32'h1A53454E;
  - state enum (IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR);
  - `TRAINER_LEN` = 512, `PRG_BANK` = 16384, `CHR_BANK` = 8192.
- **Sub-module `ines_byte_fifo`:**
  - 30-bit entries `{addr, data}`;
  - `FIFO_DEPTH` deep;
  - push, pop, full, empty and flush signals.

## Test plan
- **Minimal image, no wait states.** Header 4E 45 53 1A 01 01 01 00…, then 24576 bytes, with `mem_ack` 1 cycle after each `mem_req`.
  - Expect 16384 writes at 0x000000–0x003FFF, 8192 at 0x200000–0x201FFF.
  - Expect `mapper`=0, `mirroring`=1, then `loaded`=1 once `rom_loading` falls.
- **Trainer plus mapper.** Byte6=0x14, byte7=0x40, PRG=2, CHR=0.
  - Expect `mapper`=0x41 and the first 512 post-header bytes not written.
  - Expect the first write to be addr 0 carrying byte 528, and 32768 writes total.
- **Bad header.** Magic byte 2 = 0x00.
  - Expect `error`=1, `header_valid`=0, and zero `mem_req`.
- **SDRAM stall.** Hold `mem_ack` off for 20 cycles while bytes arrive every 4 cycles.
  - Expect FIFO overflow, `error`=1, and state ERROR.
  - Repeat with a 12-cycle stall: no error.
- **Truncation.** Drop `rom_loading` after 1000 PRG bytes.
  - Expect `error`=1, `loaded`=0, and all 1000 writes completed.
- **Mid-load events.**
  - Assert `resetn`=0 mid-PRG: all outputs 0 immediately (asynchronously).
  - A new `rom_loading` rise mid-CHR restarts cleanly, with the first write at addr 0.
